// File: rtl/mem_exception_stage.sv
// EX/MEM pipeline register with data-alignment exception collection and squash control.
// Optional macro MEM_ALIGN_CHECK_EN enables AdEL/AdES (bits 26/25) generation.
module mem_exception_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_pc_i,
  input  logic        ex_is_branch_i,
  input  logic [31:0] ex_exception_type_i,
  input  logic [3:0]  ex_mem_op_i,
  input  logic [31:0] ex_mem_addr_i,
  input  logic [31:0] ex_wdata_i,
  output logic        valid_o,
  output logic [31:0] exception_type_o,
  output logic [31:0] pc_o,
  output logic [31:0] exception_addr_o,
  output logic        now_in_delayslot_o,
  output logic        mem_en_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o
);
  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] SQUASH = 1'b1;

  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic [0:0]  state;
  logic        valid_r, ds_r, prev_branch;
  logic [31:0] pc_r, addr_r, wdata_r;
  logic [4:0]  exc_hi;   // upstream bits 31..27
  logic        exc_eret; // upstream bit 0
  logic [3:0]  op_r;

  logic        is_load, is_store, adel, ades, run;
  logic [31:0] vec;
  logic [3:0]  strb;
  logic        unused;

  assign unused = ^ex_exception_type_i[26:1];

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= RUN;
      valid_r     <= 1'b0;
      ds_r        <= 1'b0;
      prev_branch <= 1'b0;
      pc_r        <= RESET_PC;
      addr_r      <= '0;
      wdata_r     <= '0;
      exc_hi      <= '0;
      exc_eret    <= 1'b0;
      op_r        <= '0;
    end else if (flush_i) begin
      state       <= RUN;
      valid_r     <= 1'b0;
      ds_r        <= 1'b0;
      prev_branch <= 1'b0;
      exc_hi      <= '0;
      exc_eret    <= 1'b0;
      op_r        <= '0;
    end else if (!stall_i) begin
      // An exception leaves the stage on this edge; everything behind it becomes a bubble.
      if (state == RUN && |vec) state <= SQUASH;
      valid_r  <= ex_valid_i && (state == RUN);
      ds_r     <= prev_branch && ex_valid_i;
      if (ex_valid_i && state == RUN) prev_branch <= ex_is_branch_i;
      pc_r     <= ex_pc_i;
      addr_r   <= ex_mem_addr_i;
      wdata_r  <= ex_wdata_i;
      exc_hi   <= ex_exception_type_i[31:27];
      exc_eret <= ex_exception_type_i[0];
      op_r     <= ex_mem_op_i;
    end
  end

  assign is_load  = (op_r >= OP_LB) && (op_r <= OP_LW);
  assign is_store = (op_r >= OP_SB) && (op_r <= OP_SW);

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned;
  assign misaligned = (((op_r == OP_LH) || (op_r == OP_LHU) || (op_r == OP_SH)) && addr_r[0]) ||
                      (((op_r == OP_LW) || (op_r == OP_SW)) && (addr_r[1:0] != 2'b00));
  // A fetch fault on the same instruction wins over any data-side fault.
  assign adel = valid_r && is_load  && misaligned && !exc_hi[4];
  assign ades = valid_r && is_store && misaligned && !exc_hi[4];
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  assign vec = valid_r ? {exc_hi, adel, ades, 24'd0, exc_eret} : 32'd0;
  assign run = (state == RUN);

  assign valid_o            = valid_r && run;
  assign exception_type_o   = run ? vec : 32'd0;
  assign pc_o               = pc_r;
  assign now_in_delayslot_o = ds_r;
`ifdef MEM_ALIGN_CHECK_EN
  assign exception_addr_o   = (run && (adel || ades)) ? addr_r : 32'd0;
`else
  assign exception_addr_o   = 32'd0;
`endif

  assign mem_en_o   = valid_r && (is_load || is_store) && (vec == 32'd0) && run;
  assign mem_addr_o = {addr_r[31:2], 2'b00};

  always_comb begin
    strb        = 4'b0000;
    mem_wdata_o = wdata_r;
    case (op_r)
      OP_SB: begin
        strb        = 4'b0001 << addr_r[1:0];
        mem_wdata_o = {4{wdata_r[7:0]}};
      end
      OP_SH: begin
        strb        = 4'b0011 << {addr_r[1], 1'b0};
        mem_wdata_o = {2{wdata_r[15:0]}};
      end
      OP_SW:   strb = 4'b1111;
      default: strb = 4'b0000;
    endcase
  end

  assign mem_we_o = mem_en_o ? strb : 4'b0000;

endmodule
